// File: rtl/regs_sync_bank.sv
// Integer register file, 2 registered read ports + 1 write port, write-first bypass; read latency 1 cycle.
// Backpressure: busy is high during the post-reset clear sweep; the core must stall, reads/writes are ignored.
module regs_sync_bank #(
  parameter int    DATA_W         = 32,
  parameter int    ADDR_W         = 5,
  parameter string ZERO_REG       = "TRUE",
  parameter string CLEAR_ON_RESET = "TRUE"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1a,
  input  logic              rs1r,
  output logic [DATA_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2a,
  input  logic              rs2r,
  output logic [DATA_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rda,
  input  logic [DATA_W-1:0] rd,
  input  logic              rdw,
  output logic              busy
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam bit ZERO_EN  = (ZERO_REG == "TRUE");
  localparam bit CLEAR_EN = (CLEAR_ON_RESET == "TRUE");

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd1_val;
  logic [DATA_W-1:0] rd2_val;

  // One physical write port shared by the sweep and writeback keeps the array RAM-mappable.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rda;
    wr_data = rd;
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = '0;
      end else begin
        wr_en = rdw && !(ZERO_EN && (rda == '0));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Bypass compares against the raw write request so a same-edge read sees rd.
  always_comb begin
    rd1_val = mem[rs1a];
    if (ZERO_EN && (rs1a == '0)) begin
      rd1_val = '0;
    end else if (rdw && (rda == rs1a)) begin
      rd1_val = rd;
    end
  end

  always_comb begin
    rd2_val = mem[rs2a];
    if (ZERO_EN && (rs2a == '0)) begin
      rd2_val = '0;
    end else if (rdw && (rda == rs2a)) begin
      rd2_val = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR_EN ? ST_CLEAR : ST_RUN;
      cnt   <= '0;
      busy  <= CLEAR_EN;
      rs1   <= '0;
      rs2   <= '0;
    end else if (state == ST_CLEAR) begin
      rs1 <= '0;
      rs2 <= '0;
      if (cnt == '1) begin
        state <= ST_RUN;
        busy  <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      if (rs1r) begin
        rs1 <= rd1_val;
      end
      if (rs2r) begin
        rs2 <= rd2_val;
      end
    end
  end

endmodule

// File: tb/tb_regs_sync_bank.sv
// Directed bench: default bank, ZERO_REG="FALSE" bank, and a 16-entry bank without clear sweep.
module tb_regs_sync_bank;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1a, rs2a, rda;
  logic        rs1r, rs2r, rdw;
  logic [31:0] rd;
  logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
  logic        a_busy, b_busy;

  logic        c_rst_n;
  logic [3:0]  c_rs1a, c_rs2a, c_rda;
  logic        c_rs1r, c_rs2r, c_rdw;
  logic [31:0] c_rd;
  logic [31:0] c_rs1, c_rs2;
  logic        c_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  regs_sync_bank dut_a (
    .clk(clk), .rst_n(rst_n),
    .rs1a(rs1a), .rs1r(rs1r), .rs1(a_rs1),
    .rs2a(rs2a), .rs2r(rs2r), .rs2(a_rs2),
    .rda(rda), .rd(rd), .rdw(rdw), .busy(a_busy)
  );

  regs_sync_bank #(.ZERO_REG("FALSE")) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rs1a(rs1a), .rs1r(rs1r), .rs1(b_rs1),
    .rs2a(rs2a), .rs2r(rs2r), .rs2(b_rs2),
    .rda(rda), .rd(rd), .rdw(rdw), .busy(b_busy)
  );

  regs_sync_bank #(.ADDR_W(4), .CLEAR_ON_RESET("FALSE")) dut_c (
    .clk(clk), .rst_n(c_rst_n),
    .rs1a(c_rs1a), .rs1r(c_rs1r), .rs1(c_rs1),
    .rs2a(c_rs2a), .rs2r(c_rs2r), .rs2(c_rs2),
    .rda(c_rda), .rd(c_rd), .rdw(c_rdw), .busy(c_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  typedef struct {
    logic        rdw;
    logic [4:0]  rda;
    logic [31:0] rd;
    logic        rs1r;
    logic [4:0]  rs1a;
    logic        rs2r;
    logic [4:0]  rs2a;
    logic [31:0] e1a;
    logic [31:0] e2a;
    logic [31:0] e1b;
    logic [31:0] e2b;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n;
    bit zero_ok;

    //            rdw   rda    rd            rs1r  rs1a   rs2r  rs2a   A.rs1         A.rs2         B.rs1         B.rs2
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd6,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b1, 5'd7,  32'h12345678, 1'b1, 5'd7,  1'b1, 5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd0,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd5,  32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 5'd5,  32'hCAFEF00D, 1'b1, 5'd5,  1'b1, 5'd0,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'hFFFFFFFF};
    vecs[8]  = '{1'b1, 5'd0,  32'h11112222, 1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h11112222, 32'hFFFFFFFF};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd31, 32'h0,        32'h0,        32'h11112222, 32'h0};
    vecs[10] = '{1'b1, 5'd31, 32'h00000031, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h11112222, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd5,  32'h00000031, 32'hCAFEF00D, 32'h00000031, 32'hCAFEF00D};

    rst_n = 1'b0; rs1a = '0; rs2a = '0; rda = '0; rs1r = 1'b0; rs2r = 1'b0; rdw = 1'b0; rd = '0;
    c_rst_n = 1'b0; c_rs1a = '0; c_rs2a = '0; c_rda = '0; c_rs1r = 1'b0; c_rs2r = 1'b0;
    c_rdw = 1'b0; c_rd = '0;

    // Reset state
    tick();
    tick();
    check("reset_a_busy", {31'd0, a_busy}, 32'd1);
    check("reset_b_busy", {31'd0, b_busy}, 32'd1);
    check("reset_a_rs1", a_rs1, 32'h0);
    check("reset_a_rs2", a_rs2, 32'h0);
    check("reset_c_busy", {31'd0, c_busy}, 32'd0);

    // Sweep length after release
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (!a_busy) break;
    end
    check("sweep_len", n, 32'd32);
    check("sweep_b_busy", {31'd0, b_busy}, 32'd0);

    // Every entry cleared
    rs1r = 1'b1;
    rs2r = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1a = 5'(i);
      rs2a = 5'(31 - i);
      tick();
      check($sformatf("clr_rs1_%0d", i), a_rs1, 32'h0);
      check($sformatf("clr_rs2_%0d", 31 - i), a_rs2, 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      rdw = vecs[i].rdw;   rda = vecs[i].rda;   rd = vecs[i].rd;
      rs1r = vecs[i].rs1r; rs1a = vecs[i].rs1a;
      rs2r = vecs[i].rs2r; rs2a = vecs[i].rs2a;
      tick();
      check($sformatf("v%0d_a_rs1", i), a_rs1, vecs[i].e1a);
      check($sformatf("v%0d_a_rs2", i), a_rs2, vecs[i].e2a);
      check($sformatf("v%0d_b_rs1", i), b_rs1, vecs[i].e1b);
      check($sformatf("v%0d_b_rs2", i), b_rs2, vecs[i].e2b);
      check($sformatf("v%0d_a_busy", i), {31'd0, a_busy}, 32'd0);
    end
    rdw = 1'b0; rs1r = 1'b0; rs2r = 1'b0;

    // Reset dropped at sweep cycle 10 restarts the sweep
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy_before", {31'd0, a_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_busy_reset", {31'd0, a_busy}, 32'd1);
    rst_n = 1'b1;
    rdw = 1'b1; rda = 5'd9; rd = 32'h55AA55AA;
    rs1r = 1'b1; rs1a = 5'd9; rs2r = 1'b1; rs2a = 5'd5;
    n = 0;
    zero_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (a_rs1 !== 32'h0 || a_rs2 !== 32'h0) zero_ok = 1'b0;
      if (!a_busy) break;
    end
    rdw = 1'b0;
    check("mid_sweep_len", n, 32'd32);
    check("mid_sweep_rs_zero", {31'd0, zero_ok}, 32'd1);
    tick();
    check("mid_lost_write", a_rs1, 32'h0);
    check("mid_cleared_5", a_rs2, 32'h0);
    check("mid_b_lost_write", b_rs1, 32'h0);

    rs1r = 1'b0; rs2r = 1'b0;
    rdw = 1'b1; rda = 5'd9; rd = 32'h55AA55AA;
    tick();
    rdw = 1'b0; rs1r = 1'b1; rs1a = 5'd9;
    tick();
    check("post_sweep_write", a_rs1, 32'h55AA55AA);

    // 16-entry bank without sweep keeps contents across reset
    c_rst_n = 1'b1;
    c_rdw = 1'b1; c_rda = 4'd3; c_rd = 32'hA5A5A5A5;
    tick();
    c_rdw = 1'b0;
    c_rst_n = 1'b0;
    tick();
    check("c_reset_busy", {31'd0, c_busy}, 32'd0);
    check("c_reset_rs1", c_rs1, 32'h0);
    c_rst_n = 1'b1;
    c_rs1r = 1'b1; c_rs1a = 4'd3;
    c_rs2r = 1'b1; c_rs2a = 4'd3;
    tick();
    check("c_busy_after", {31'd0, c_busy}, 32'd0);
    check("c_keep_rs1", c_rs1, 32'hA5A5A5A5);
    check("c_keep_rs2", c_rs2, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
